// File: rtl/pwm_slice16.sv
// Single-channel 16-step PWM slice that tracks an external free-running 4-bit count,
// with a one-entry duty mailbox, period-boundary duty updates and count-continuity checking.
module pwm_slice16 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] cnt,
  input  logic [4:0] duty_in,
  input  logic       duty_valid,
  output logic       duty_ready,
  input  logic       err_clr,
  output logic       pwm_out,
  output logic       period_done,
  output logic       sync_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [4:0] duty_act_r;
  logic [4:0] pend_duty_r;
  logic       pend_r;
  logic [3:0] prev_cnt_r;

  logic       active_s;
  logic       next_active_s;
  logic       disc_s;
  logic       last_s;
  logic       apply_s;
  logic       accept_s;
  logic [4:0] duty_use_s;
  logic [3:0] exp_cnt_s;

  function automatic logic [4:0] clamp_duty(input logic [4:0] d);
    clamp_duty = (d > 5'd16) ? 5'd16 : d;
  endfunction

  assign duty_ready = ~pend_r;

  // Decode period boundary, continuity and mailbox handshake conditions.
  always_comb begin
    active_s  = (state_r == RUN) || (state_r == STOP);
    exp_cnt_s = prev_cnt_r + 4'd1;
    disc_s    = active_s && (cnt != exp_cnt_s);
    last_s    = active_s && (cnt == 4'd15);
    apply_s   = pend_r && (last_s || !active_s);
    accept_s  = duty_valid && !pend_r;
    // Outside an active period a pending duty is applied this edge, so use it at once.
    if (pend_r && !active_s) begin
      duty_use_s = pend_duty_r;
    end else begin
      duty_use_s = duty_act_r;
    end
  end

  // Next-state logic for the run/stop sequencing.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (en) state_s = ARM;
        else    state_s = IDLE;
      end
      ARM: begin
        if (!en)                state_s = IDLE;
        else if (cnt == 4'd0)   state_s = RUN;
        else                    state_s = ARM;
      end
      RUN: begin
        if (disc_s)   state_s = ARM;
        else if (!en) state_s = STOP;
        else          state_s = RUN;
      end
      STOP: begin
        if (disc_s)              state_s = ARM;
        else if (en)             state_s = RUN;
        else if (cnt == 4'd15)   state_s = IDLE;
        else                     state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
    next_active_s = (state_s == RUN) || (state_s == STOP);
  end

  // State, waveform and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pwm_out     <= 1'b0;
      period_done <= 1'b0;
      sync_err    <= 1'b0;
      prev_cnt_r  <= 4'd0;
    end else begin
      state_r     <= state_s;
      pwm_out     <= next_active_s ? ({1'b0, cnt} < duty_use_s) : 1'b0;
      period_done <= last_s;
      if (disc_s) begin
        sync_err <= 1'b1;
      end else if (err_clr) begin
        sync_err <= 1'b0;
      end else begin
        sync_err <= sync_err;
      end
      if (next_active_s) begin
        prev_cnt_r <= cnt;
      end else begin
        prev_cnt_r <= prev_cnt_r;
      end
    end
  end

  // Duty mailbox: accept into pending, move to active at a safe boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_act_r  <= 5'd0;
      pend_duty_r <= 5'd0;
      pend_r      <= 1'b0;
    end else if (apply_s) begin
      duty_act_r  <= pend_duty_r;
      pend_r      <= 1'b0;
    end else if (accept_s) begin
      pend_duty_r <= clamp_duty(duty_in);
      pend_r      <= 1'b1;
    end else begin
      pend_r      <= pend_r;
    end
  end

endmodule

// File: tb/tb_pwm_slice16.sv
// Self-checking bench for pwm_slice16: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the run/stop/duty rules.
module tb_pwm_slice16;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] cnt;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       err_clr;
  logic       pwm_out;
  logic       period_done;
  logic       sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mode 0 idle, 1 waiting for period start, 2 running, 3 finishing
  int m_mode, m_prev, m_duty, m_pend_val, sampled_cnt;
  bit m_pend, m_pwm, m_pd, m_err;

  pwm_slice16 dut (
    .clk(clk), .reset(reset), .en(en), .cnt(cnt), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(duty_ready), .err_clr(err_clr),
    .pwm_out(pwm_out), .period_done(period_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_duty = 0; m_pend_val = 0;
    m_pend = 1'b0; m_pwm = 1'b0; m_pd = 1'b0; m_err = 1'b0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then advance cnt.
  task automatic tick();
    int c, nm, deff;
    bit act, disc, last;
    @(posedge clk);
    c = int'(cnt);
    sampled_cnt = c;
    if (!reset) begin
      model_reset();
    end else begin
      act  = (m_mode >= 2);
      disc = act && (c != (m_prev + 1) % 16);
      last = act && (c == 15);
      deff = (!act && m_pend) ? m_pend_val : m_duty;
      case (m_mode)
        0:       nm = en ? 1 : 0;
        1:       nm = !en ? 0 : ((c == 0) ? 2 : 1);
        2:       nm = disc ? 1 : (!en ? 3 : 2);
        default: nm = disc ? 1 : (en ? 2 : ((c == 15) ? 0 : 3));
      endcase
      m_pwm = (nm >= 2) && (c < deff);
      m_pd  = last;
      if (disc) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      if (nm >= 2) m_prev = c;
      if (m_pend && (last || !act)) begin
        m_duty = m_pend_val;
        m_pend = 1'b0;
      end else if (duty_valid && !m_pend) begin
        m_pend = 1'b1;
        m_pend_val = (int'(duty_in) > 16) ? 16 : int'(duty_in);
      end
      m_mode = nm;
    end
    #1;
    cnt = cnt + 4'd1;
  endtask

  task automatic do_reset();
    reset = 1'b0; en = 1'b0; duty_valid = 1'b0; duty_in = 5'd0; err_clr = 1'b0; cnt = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic offer(input logic [4:0] d);
    duty_in = d; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
  endtask

  task automatic run_to(input logic [3:0] target);
    for (int k = 0; k < 40 && cnt != target; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; duty_valid = 1'b1; duty_in = 5'd9; err_clr = 1'b0; cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pwm_out, period_done, sync_err, duty_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0001", {pwm_out, period_done, sync_err, duty_ready});
    end
    do_reset();
    repeat (5) begin
      tick();
      n_checks++;
      if (pwm_out !== 1'b0 || duty_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_idle: pwm %b ready %b want 0 1", pwm_out, duty_ready);
      end
    end
  endtask

  task automatic test_duty5();
    bit started = 1'b0;
    do_reset();
    offer(5'd5);
    tick();
    run_to(4'd9);
    en = 1'b1;
    repeat (44) begin
      tick();
      if (sampled_cnt == 0) started = 1'b1;
      n_checks++;
      if ({pwm_out, period_done, sync_err, duty_ready} !== {m_pwm, m_pd, m_err, ~m_pend} ||
          pwm_out !== (started && sampled_cnt < 5) || period_done !== (started && sampled_cnt == 15)) begin
        n_fail++; $display("FAIL duty5 cnt=%0d: got pwm %b pd %b want pwm %b pd %b", sampled_cnt,
                           pwm_out, period_done, started && sampled_cnt < 5, started && sampled_cnt == 15);
      end
    end
  endtask

  task automatic test_extremes();
    logic [4:0] dv [2];
    dv[0] = 5'd0; dv[1] = 5'd20;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      offer(dv[i]);
      en = 1'b1;
      run_to(4'd0);
      tick();
      for (int k = 0; k < 47; k++) begin
        tick();
        n_checks++;
        if (pwm_out !== (i == 1) || pwm_out !== m_pwm) begin
          n_fail++; $display("FAIL extreme_duty%0d cnt=%0d: got %b want %b", dv[i], sampled_cnt, pwm_out, i == 1);
        end
      end
    end
  endtask

  task automatic test_update();
    bit second = 1'b0;
    do_reset();
    offer(5'd4);
    en = 1'b1;
    run_to(4'd0);
    run_to(4'd6);
    offer(5'd12);
    n_checks++;
    if (duty_ready !== 1'b0) begin
      n_fail++; $display("FAIL update_ready_low: got %b want 0", duty_ready);
    end
    repeat (26) begin
      tick();
      if (sampled_cnt == 0) second = 1'b1;
      n_checks++;
      if (pwm_out !== (sampled_cnt < (second ? 12 : 4)) || duty_ready !== (second || sampled_cnt == 15) ||
          {pwm_out, duty_ready} !== {m_pwm, ~m_pend}) begin
        n_fail++; $display("FAIL update cnt=%0d: got pwm %b ready %b want pwm %b ready %b", sampled_cnt, pwm_out,
                           duty_ready, sampled_cnt < (second ? 12 : 4), second || sampled_cnt == 15);
      end
    end
  endtask

  task automatic test_stop_restart();
    do_reset();
    offer(5'd6);
    en = 1'b1;
    run_to(4'd0);
    run_to(4'd3);
    en = 1'b0;
    run_to(4'd0);
    repeat (10) begin
      tick();
      n_checks++;
      if (pwm_out !== 1'b0 || m_mode != 0) begin
        n_fail++; $display("FAIL stop_idle cnt=%0d: got %b want 0", sampled_cnt, pwm_out);
      end
    end
    en = 1'b1;
    run_to(4'd0);
    run_to(4'd3);
    en = 1'b0;
    run_to(4'd10);
    en = 1'b1;
    repeat (36) begin
      tick();
      n_checks++;
      if (pwm_out !== (sampled_cnt < 6) || pwm_out !== m_pwm) begin
        n_fail++; $display("FAIL stop_resume cnt=%0d: got %b want %b", sampled_cnt, pwm_out, sampled_cnt < 6);
      end
    end
  endtask

  task automatic test_sync_err();
    do_reset();
    offer(5'd8);
    en = 1'b1;
    run_to(4'd0);
    run_to(4'd8);
    cnt = 4'd11;
    tick();
    n_checks++;
    if (sync_err !== 1'b1 || pwm_out !== 1'b0) begin
      n_fail++; $display("FAIL jump_detect: got err %b pwm %b want 1 0", sync_err, pwm_out);
    end
    repeat (24) begin
      tick();
      n_checks++;
      if ({pwm_out, period_done, sync_err} !== {m_pwm, m_pd, m_err}) begin
        n_fail++; $display("FAIL resync cnt=%0d: got %b want %b", sampled_cnt,
                           {pwm_out, period_done, sync_err}, {m_pwm, m_pd, m_err});
      end
    end
    run_to(4'd8);
    cnt = 4'd11; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (sync_err !== 1'b1) begin
      n_fail++; $display("FAIL set_beats_clear: got %b want 1", sync_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (sync_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", sync_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    offer(5'd8);
    en = 1'b1;
    run_to(4'd0);
    run_to(4'd2);
    duty_in = 5'd3; duty_valid = 1'b1;
    #2;
    n_checks++;
    if (pwm_out !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_pwm: got %b want 1", pwm_out);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (pwm_out !== 1'b0) begin
      n_fail++; $display("FAIL async_drop: got %b want 0", pwm_out);
    end
    @(negedge clk);
    duty_valid = 1'b0;
    reset = 1'b1;
    model_reset();
    n_checks++;
    if (duty_ready !== 1'b1 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_ready: got ready %b err %b want 1 0", duty_ready, sync_err);
    end
    repeat (40) begin
      tick();
      n_checks++;
      if (pwm_out !== 1'b0 || pwm_out !== m_pwm) begin
        n_fail++; $display("FAIL post_reset_duty0 cnt=%0d: got %b want 0", sampled_cnt, pwm_out);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      duty_valid = ($urandom_range(0, 5) == 0);
      duty_in    = 5'($urandom_range(0, 31));
      err_clr    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) cnt = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if ({pwm_out, period_done, sync_err, duty_ready} !== {m_pwm, m_pd, m_err, ~m_pend}) begin
        n_fail++; $display("FAIL random step %0d cnt=%0d: got %b want %b", i, sampled_cnt,
                           {pwm_out, period_done, sync_err, duty_ready}, {m_pwm, m_pd, m_err, ~m_pend});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_duty5();
    test_extremes();
    test_update();
    test_stop_restart();
    test_sync_err();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
